// File: rtl/output_buffer_if.sv
`default_nettype none
// ============================================================================
// Module      : output_buffer_if
// Description : Drain-side valid/ready word bus leaving the output buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface output_buffer_if #(
    parameter int DATA_W = 16
);
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_bank;
    logic [2:0]        out_col;
    logic              out_ready;

    modport master (
        output out_valid,
        output out_data,
        output out_bank,
        output out_col,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_bank,
        input  out_col,
        output out_ready
    );
endinterface
`default_nettype wire

// File: rtl/output_buffer.sv
`default_nettype none
// ============================================================================
// Module      : output_buffer
// Description : Two banks of seven per-column psum FIFOs drained round-robin
//               onto a registered valid/ready port. Optional ReLU clamp at
//               FIFO write is enabled by defining OUTBUFF_RELU_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module output_buffer #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 16
) (
    input  wire logic                 clk,
    input  wire logic                 rst,
    input  wire logic [1:0]           mode,
    input  wire logic                 change_mode,
    input  wire logic [6:0][DATA_W:0] psum_row2_in,
    input  wire logic [6:0][DATA_W:0] psum_row4_in,
    input  wire logic [6:0][DATA_W:0] psum_row6_in,
    output logic      [6:0]           outbuff_row2_ack,
    output logic      [6:0]           outbuff_row4_ack,
    output logic      [6:0]           outbuff_row6_ack,
    output_buffer_if.master           ob,
    output logic                      busy,
    output logic                      error
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam int c_NUM_Q = 14;

    localparam logic [1:0] c_MODE1 = 2'd0;
    localparam logic [1:0] c_MODE2 = 2'd1;
    localparam logic [1:0] c_MODE3 = 2'd2;
    localparam logic [1:0] c_MODE4 = 2'd3;

    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_AW-1:0]    c_PTR_ONE  = c_AW'(1);

    logic [1:0]         r_cur_mode;
    logic               r_out_valid;
    logic [DATA_W-1:0]  r_out_data;
    logic               r_out_bank;
    logic [2:0]         r_out_col;
    logic [3:0]         r_rr_ptr;
    logic               r_error;

    logic [c_NUM_Q-1:0] w_sel;
    logic [c_NUM_Q-1:0] w_src_vld;
    logic [c_NUM_Q-1:0] w_full;
    logic [c_NUM_Q-1:0] w_nonempty;
    logic [c_NUM_Q-1:0] w_push;
    logic [c_NUM_Q-1:0] w_pop;
    logic [DATA_W-1:0]  w_src_data [c_NUM_Q];
    logic [DATA_W-1:0]  w_wr_data  [c_NUM_Q];
    logic [DATA_W-1:0]  w_rd_data  [c_NUM_Q];

    logic               w_busy;
    logic               w_grant_vld;
    logic [3:0]         w_grant_idx;
    logic [4:0]         w_sum;
    logic [3:0]         w_cand;
    logic               w_load;
    logic [2:0]         w_grant_col;

    // Queue index is bank*7 + col; bank 0 is fed only in MODE4.
    always_comb begin
        w_sel     = '0;
        w_src_vld = '0;
        for (int c = 0; c < 7; c++) begin
            w_sel[c]          = (r_cur_mode == c_MODE4);
            w_src_vld[c]      = psum_row2_in[c][DATA_W];
            w_src_data[c]     = psum_row2_in[c][DATA_W-1:0];
            w_sel[7+c]        = (r_cur_mode != c_MODE1);
            if (r_cur_mode == c_MODE2) begin
                w_src_vld[7+c]  = psum_row4_in[c][DATA_W];
                w_src_data[7+c] = psum_row4_in[c][DATA_W-1:0];
            end else begin
                w_src_vld[7+c]  = psum_row6_in[c][DATA_W];
                w_src_data[7+c] = psum_row6_in[c][DATA_W-1:0];
            end
        end
    end

    assign w_push           = w_sel & w_src_vld & ~w_full;
    assign outbuff_row2_ack = w_push[6:0];
    assign outbuff_row4_ack = (r_cur_mode == c_MODE2) ? w_push[13:7] : 7'd0;
    assign outbuff_row6_ack = ((r_cur_mode == c_MODE3) || (r_cur_mode == c_MODE4))
                            ? w_push[13:7] : 7'd0;

    generate
        for (genvar i = 0; i < c_NUM_Q; i++) begin : g_fifo
            logic [c_CNT_W-1:0] r_cnt;
            logic [c_AW-1:0]    r_wr_ptr;
            logic [c_AW-1:0]    r_rd_ptr;
            logic [DATA_W-1:0]  r_mem [DEPTH];

`ifdef OUTBUFF_RELU_EN
            assign w_wr_data[i] = w_src_data[i][DATA_W-1] ? '0 : w_src_data[i];
`else
            assign w_wr_data[i] = w_src_data[i];
`endif

            // Full is taken from the pre-edge count, so a same-edge pop never frees a slot.
            assign w_full[i]     = (r_cnt == c_FULL_CNT);
            assign w_nonempty[i] = (r_cnt != '0);
            assign w_rd_data[i]  = r_mem[r_rd_ptr];
            assign w_pop[i]      = w_load && (w_grant_idx == 4'(i));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    r_cnt    <= '0;
                    r_wr_ptr <= '0;
                    r_rd_ptr <= '0;
                end else begin
                    if (w_push[i]) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                    if (w_pop[i])  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
                    case ({w_push[i], w_pop[i]})
                        2'b10:   r_cnt <= r_cnt + c_CNT_ONE;
                        2'b01:   r_cnt <= r_cnt - c_CNT_ONE;
                        default: r_cnt <= r_cnt;
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (w_push[i]) r_mem[r_wr_ptr] <= w_wr_data[i];
            end
        end
    endgenerate

    // First non-empty queue at or after the round-robin pointer, with wrap.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        w_sum       = '0;
        w_cand      = '0;
        for (int k = 0; k < c_NUM_Q; k++) begin
            w_sum  = {1'b0, r_rr_ptr} + 5'(k);
            w_cand = (w_sum >= 5'd14) ? 4'(w_sum - 5'd14) : w_sum[3:0];
            if (!w_grant_vld && w_nonempty[w_cand]) begin
                w_grant_vld = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    assign w_load      = (!r_out_valid || ob.out_ready) && w_grant_vld;
    assign w_grant_col = (w_grant_idx >= 4'd7) ? 3'(w_grant_idx - 4'd7) : w_grant_idx[2:0];
    assign w_busy      = (|w_nonempty) || r_out_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur_mode  <= c_MODE1;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_bank  <= 1'b0;
            r_out_col   <= '0;
            r_rr_ptr    <= '0;
            r_error     <= 1'b0;
        end else begin
            if (!r_out_valid || ob.out_ready) r_out_valid <= w_grant_vld;
            if (w_load) begin
                r_out_data <= w_rd_data[w_grant_idx];
                r_out_bank <= (w_grant_idx >= 4'd7);
                r_out_col  <= w_grant_col;
                r_rr_ptr   <= (w_grant_idx == 4'd13) ? 4'd0 : w_grant_idx + 4'd1;
            end
            // Mode may only change with nothing in flight; otherwise flag it.
            r_error <= change_mode && w_busy;
            if (change_mode && !w_busy) r_cur_mode <= mode;
        end
    end

    assign ob.out_valid = r_out_valid;
    assign ob.out_data  = r_out_data;
    assign ob.out_bank  = r_out_bank;
    assign ob.out_col   = r_out_col;
    assign busy         = w_busy;
    assign error        = r_error;

endmodule
`default_nettype wire

// File: tb/tb_output_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_buffer
// Description : Self-checking bench for output_buffer: vector table, directed
//               corner sequences and random traffic against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_buffer;

    localparam int DEPTH = 4;
    localparam int DW    = 16;

`ifdef OUTBUFF_RELU_EN
    localparam logic [DW-1:0] c_NEG_EXP = 16'h0000;
`else
    localparam logic [DW-1:0] c_NEG_EXP = 16'hFFF0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       mode;
    logic             change_mode;
    logic [6:0][DW:0] row2, row4, row6;
    logic [6:0]       ack2, ack4, ack6;
    logic             busy, error;

    always #5 clk = ~clk;

    output_buffer_if #(.DATA_W(DW)) u_if ();

    output_buffer #(.DEPTH(DEPTH), .DATA_W(DW)) dut (
        .clk              (clk),
        .rst              (rst),
        .mode             (mode),
        .change_mode      (change_mode),
        .psum_row2_in     (row2),
        .psum_row4_in     (row4),
        .psum_row6_in     (row6),
        .outbuff_row2_ack (ack2),
        .outbuff_row4_ack (ack4),
        .outbuff_row6_ack (ack6),
        .ob               (u_if),
        .busy             (busy),
        .error            (error)
    );

    int n_vec  = 0;
    int n_miss = 0;

    // Reference model: one queue per (bank, col), index bank*7+col.
    logic [DW-1:0] mq [14][$];
    int            m_ptr;
    bit            m_ov;
    logic [DW-1:0] m_od;
    bit            m_ob;
    int            m_oc;
    logic [1:0]    m_mode;
    bit            m_err;

    logic [6:0]    obs2, obs4, obs6;
    bit            obs_ov_pre;
    logic [DW-1:0] obs_od_pre;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] relu(logic [DW-1:0] d);
`ifdef OUTBUFF_RELU_EN
        return d[DW-1] ? '0 : d;
`else
        return d;
`endif
    endfunction

    function automatic bit model_busy();
        bit b = m_ov;
        for (int i = 0; i < 14; i++) if (mq[i].size() > 0) b = 1'b1;
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 14; i++) mq[i].delete();
        m_ptr = 0; m_ov = 0; m_od = '0; m_ob = 0; m_oc = 0; m_mode = 2'd0; m_err = 0;
    endtask

    // Mode encoding: 0=MODE1, 1=MODE2, 2=MODE3, 3=MODE4.
    task automatic model_acks(output logic [6:0] a2, output logic [6:0] a4, output logic [6:0] a6);
        for (int c = 0; c < 7; c++) begin
            a2[c] = (m_mode == 2'd3) && row2[c][DW] && (mq[c].size() < DEPTH);
            a4[c] = (m_mode == 2'd1) && row4[c][DW] && (mq[7+c].size() < DEPTH);
            a6[c] = ((m_mode == 2'd2) || (m_mode == 2'd3)) && row6[c][DW] && (mq[7+c].size() < DEPTH);
        end
    endtask

    task automatic model_step();
        bit         busy_pre = model_busy();
        int         g = -1;
        logic [6:0] a2, a4, a6;
        model_acks(a2, a4, a6);
        if (!m_ov || u_if.out_ready) begin
            for (int k = 0; k < 14; k++) begin
                int i = (m_ptr + k) % 14;
                if (g < 0 && mq[i].size() > 0) g = i;
            end
            if (g >= 0) begin
                m_od = mq[g].pop_front(); m_ob = (g >= 7); m_oc = g % 7;
                m_ov = 1; m_ptr = (g + 1) % 14;
            end else begin
                m_ov = 0;
            end
        end
        for (int c = 0; c < 7; c++) begin
            if (a2[c]) mq[c].push_back(relu(row2[c][DW-1:0]));
            if (a4[c]) mq[7+c].push_back(relu(row4[c][DW-1:0]));
            if (a6[c]) mq[7+c].push_back(relu(row6[c][DW-1:0]));
        end
        m_err = change_mode && busy_pre;
        if (change_mode && !busy_pre) m_mode = mode;
    endtask

    task automatic clear_inputs();
        row2 = '0; row4 = '0; row6 = '0; change_mode = 1'b0;
    endtask

    // One clock: acks checked before the edge, registered outputs after it.
    task automatic cycle();
        logic [6:0] e2, e4, e6;
        @(negedge clk);
        model_acks(e2, e4, e6);
        obs2 = ack2; obs4 = ack4; obs6 = ack6;
        obs_ov_pre = u_if.out_valid; obs_od_pre = u_if.out_data;
        check("acks", {ack2, ack4, ack6}, {e2, e4, e6});
        model_step();
        @(posedge clk); #1;
        check("out_valid", u_if.out_valid, m_ov);
        if (m_ov) check("out_word", {u_if.out_bank, u_if.out_col, u_if.out_data}, {m_ob, 3'(m_oc), m_od});
        check("busy", busy, model_busy());
        check("error", error, m_err);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", {u_if.out_valid, u_if.out_data, u_if.out_bank, u_if.out_col, busy, error,
                              ack2, ack4, ack6}, '0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic set_mode(logic [1:0] m);
        mode = m; change_mode = 1'b1;
        cycle();
        change_mode = 1'b0;
    endtask

    typedef struct packed {
        logic [1:0]    mode;
        logic [2:0]    row_sel;
        logic [2:0]    col;
        logic [DW-1:0] data;
        logic          exp_ack;
        logic          exp_valid;
        logic          exp_bank;
        logic [2:0]    exp_col;
        logic [DW-1:0] exp_data;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int         n_ack, words;
        logic       a;
        rst = 1'b0; mode = 2'd0; u_if.out_ready = 1'b1;
        clear_inputs();

        tbl[0] = '{mode:2'd1, row_sel:3'd4, col:3'd3, data:16'h0012, exp_ack:1, exp_valid:1, exp_bank:1, exp_col:3'd3, exp_data:16'h0012};
        tbl[1] = '{mode:2'd1, row_sel:3'd2, col:3'd0, data:16'h1111, exp_ack:0, exp_valid:0, exp_bank:0, exp_col:3'd0, exp_data:16'h0000};
        tbl[2] = '{mode:2'd2, row_sel:3'd6, col:3'd6, data:16'h1234, exp_ack:1, exp_valid:1, exp_bank:1, exp_col:3'd6, exp_data:16'h1234};
        tbl[3] = '{mode:2'd2, row_sel:3'd4, col:3'd1, data:16'h2222, exp_ack:0, exp_valid:0, exp_bank:0, exp_col:3'd0, exp_data:16'h0000};
        tbl[4] = '{mode:2'd3, row_sel:3'd2, col:3'd5, data:16'h00AB, exp_ack:1, exp_valid:1, exp_bank:0, exp_col:3'd5, exp_data:16'h00AB};
        tbl[5] = '{mode:2'd3, row_sel:3'd6, col:3'd0, data:16'h7FFF, exp_ack:1, exp_valid:1, exp_bank:1, exp_col:3'd0, exp_data:16'h7FFF};
        tbl[6] = '{mode:2'd0, row_sel:3'd2, col:3'd2, data:16'h3333, exp_ack:0, exp_valid:0, exp_bank:0, exp_col:3'd0, exp_data:16'h0000};
        tbl[7] = '{mode:2'd0, row_sel:3'd6, col:3'd4, data:16'h4444, exp_ack:0, exp_valid:0, exp_bank:0, exp_col:3'd0, exp_data:16'h0000};
        tbl[8] = '{mode:2'd3, row_sel:3'd6, col:3'd2, data:16'hFFF0, exp_ack:1, exp_valid:1, exp_bank:1, exp_col:3'd2, exp_data:c_NEG_EXP};
        tbl[9] = '{mode:2'd1, row_sel:3'd6, col:3'd3, data:16'h5555, exp_ack:0, exp_valid:0, exp_bank:0, exp_col:3'd0, exp_data:16'h0000};

        // Single-word routing table
        for (int i = 0; i < 10; i++) begin
            do_reset();
            u_if.out_ready = 1'b1;
            set_mode(tbl[i].mode);
            case (tbl[i].row_sel)
                3'd2:    row2[tbl[i].col] = {1'b1, tbl[i].data};
                3'd4:    row4[tbl[i].col] = {1'b1, tbl[i].data};
                default: row6[tbl[i].col] = {1'b1, tbl[i].data};
            endcase
            cycle();
            case (tbl[i].row_sel)
                3'd2:    a = obs2[tbl[i].col];
                3'd4:    a = obs4[tbl[i].col];
                default: a = obs6[tbl[i].col];
            endcase
            check("tbl_ack", a, tbl[i].exp_ack);
            clear_inputs();
            cycle();
            check("tbl_valid", u_if.out_valid, tbl[i].exp_valid);
            if (tbl[i].exp_valid)
                check("tbl_word", {u_if.out_bank, u_if.out_col, u_if.out_data},
                      {tbl[i].exp_bank, tbl[i].exp_col, tbl[i].exp_data});
        end

        // MODE4 burst from all 14 sources, drained in index order
        do_reset();
        set_mode(2'd3);
        for (int c = 0; c < 7; c++) begin
            row2[c] = {1'b1, 16'h0100 + 16'(c)};
            row6[c] = {1'b1, 16'h0200 + 16'(c)};
        end
        cycle();
        check("burst_acks", {obs2, obs6}, 14'h3FFF);
        clear_inputs();
        for (int k = 0; k < 14; k++) begin
            cycle();
            check("burst_word", {u_if.out_valid, u_if.out_bank, u_if.out_col, u_if.out_data},
                  {1'b1, (k >= 7), 3'(k % 7), ((k < 7) ? 16'h0100 : 16'h0200) + 16'(k % 7)});
        end
        cycle();
        check("burst_end", u_if.out_valid, 1'b0);

        // MODE3 stall: one word in the output register plus DEPTH queued
        do_reset();
        set_mode(2'd2);
        u_if.out_ready = 1'b0;
        n_ack = 0;
        for (int k = 0; k < 10; k++) begin
            row6[0] = {1'b1, 16'h0050 + 16'(k)};
            cycle();
            n_ack += int'(obs6[0]);
            if (k >= 1) check("stall_hold", {u_if.out_valid, u_if.out_data}, {1'b1, 16'h0050});
        end
        check("stall_acks", n_ack, DEPTH + 1);
        clear_inputs();
        u_if.out_ready = 1'b1;
        words = 0;
        for (int k = 0; k < 8; k++) begin
            cycle();
            if (obs_ov_pre) begin
                check("drain_data", obs_od_pre, 16'h0050 + 16'(words));
                words++;
            end
        end
        check("drain_words", words, DEPTH + 1);

        // MODE1 ignores every source
        do_reset();
        for (int c = 0; c < 7; c++) begin
            row2[c] = {1'b1, 16'hA000}; row4[c] = {1'b1, 16'hB000}; row6[c] = {1'b1, 16'hC000};
        end
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("mode1_acks", {obs2, obs4, obs6}, 21'd0);
            check("mode1_valid", u_if.out_valid, 1'b0);
        end
        clear_inputs();

        // Illegal mode change while busy, then legal one after drain
        do_reset();
        set_mode(2'd2);
        u_if.out_ready = 1'b0;
        row6[1] = {1'b1, 16'h0077};
        cycle();
        clear_inputs();
        cycle();
        mode = 2'd1; change_mode = 1'b1;
        cycle();
        change_mode = 1'b0;
        check("err_pulse", error, 1'b1);
        cycle();
        check("err_clear", error, 1'b0);
        row4[2] = {1'b1, 16'h0001};
        row6[2] = {1'b1, 16'h0002};
        cycle();
        check("mode_kept", {obs4[2], obs6[2]}, 2'b01);
        clear_inputs();
        u_if.out_ready = 1'b1;
        repeat (4) cycle();
        check("drained", busy, 1'b0);
        set_mode(2'd1);
        check("err_none", error, 1'b0);
        row4[2] = {1'b1, 16'h0003};
        cycle();
        check("mode_new", obs4[2], 1'b1);
        clear_inputs();

        // Random traffic against the model, with occasional mid-burst reset
        do_reset();
        for (int n = 0; n < 900; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                do_reset();
            end else begin
                int dens = (n / 100) % 3;
                int lim  = (dens == 0) ? 7 : (dens == 1) ? 1 : 19;
                for (int c = 0; c < 7; c++) begin
                    row2[c] = {($urandom_range(0, lim) == 0), 16'($urandom)};
                    row4[c] = {($urandom_range(0, lim) == 0), 16'($urandom)};
                    row6[c] = {($urandom_range(0, lim) == 0), 16'($urandom)};
                end
                mode           = 2'($urandom_range(0, 3));
                change_mode    = ($urandom_range(0, 7) == 0);
                u_if.out_ready = ($urandom_range(0, 3) != 0);
                cycle();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
